// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter (LM32 I/D buses onto one DDR slave) with round-robin tie-break and locked bursts.
// Define WB_ARB_TIMEOUT_EN to add the ack-timeout counter and ABORT state; otherwise a grant waits forever.
module wb_arbiter2 #(
   parameter int unsigned timeout_cycles = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m0_adr,
   input  logic [31:0] m0_dat_w,
   input  logic [3:0]  m0_sel,
   input  logic        m0_we,
   input  logic        m0_stb,
   input  logic        m0_cyc,
   output logic [31:0] m0_dat_r,
   output logic        m0_ack,
   output logic        m0_err,
   input  logic [31:0] m1_adr,
   input  logic [31:0] m1_dat_w,
   input  logic [3:0]  m1_sel,
   input  logic        m1_we,
   input  logic        m1_stb,
   input  logic        m1_cyc,
   output logic [31:0] m1_dat_r,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] s_adr,
   output logic [31:0] s_dat_w,
   output logic [3:0]  s_sel,
   output logic        s_we,
   output logic        s_stb,
   output logic        s_cyc,
   input  logic [31:0] s_dat_r,
   input  logic        s_ack,
   output logic [1:0]  gnt
);

   // state | meaning
   // IDLE  | no owner; slave bus idle
   // GNT0  | master 0 owns the slave until m0_cyc falls
   // GNT1  | master 1 owns the slave until m1_cyc falls
   // ABORT | stalled cycle killed; wait for owner to drop cyc
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GNT0  = 2'd1;
   localparam logic [1:0] ST_GNT1  = 2'd2;
`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [1:0] ST_ABORT = 2'd3;
   localparam logic [7:0] TERM     = 8'(timeout_cycles - 1);
`endif

   logic [1:0] state_q, state_d;
   logic       last_q, last_d;
   logic       gnt0, gnt1, cur_cyc;

   assign gnt0    = (state_q == ST_GNT0);
   assign gnt1    = (state_q == ST_GNT1);
   assign cur_cyc = gnt1 ? m1_cyc : m0_cyc;

`ifdef WB_ARB_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic       own_q, own_d;
   logic       own_cyc;

   assign own_cyc = own_q ? m1_cyc : m0_cyc;
`else
   logic unused_cfg;
   assign unused_cfg = (timeout_cycles != 0);
`endif

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_d   = 8'd0;
      err_d   = 1'b0;
      own_d   = own_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // last_q == 1 means master 1 was served last, so master 0 wins a tie
            if (m0_cyc && m1_cyc) state_d = last_q ? ST_GNT0 : ST_GNT1;
            else if (m0_cyc)      state_d = ST_GNT0;
            else if (m1_cyc)      state_d = ST_GNT1;
         end
         ST_GNT0, ST_GNT1: begin
`ifdef WB_ARB_TIMEOUT_EN
            if (s_ack)      cnt_d = 8'd0;
            else if (s_stb) cnt_d = cnt_q + 8'd1;
            else            cnt_d = cnt_q;
`endif
            if (!cur_cyc) begin
               state_d = ST_IDLE;
               last_d  = gnt1;
            end
`ifdef WB_ARB_TIMEOUT_EN
            // an ack in the terminal cycle keeps the counter from firing
            else if (s_stb && !s_ack && (cnt_q == TERM)) begin
               state_d = ST_ABORT;
               err_d   = 1'b1;
               own_d   = gnt1;
            end
`endif
         end
`ifdef WB_ARB_TIMEOUT_EN
         ST_ABORT: begin
            if (!own_cyc) begin
               state_d = ST_IDLE;
               last_d  = own_q;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
         own_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         own_q   <= own_d;
`endif
      end
   end

   // ack is masked by reset so a reply landing on the reset edge never reaches a master
   always_comb begin
      s_adr    = 32'd0;
      s_dat_w  = 32'd0;
      s_sel    = 4'd0;
      s_we     = 1'b0;
      s_stb    = 1'b0;
      s_cyc    = 1'b0;
      m0_dat_r = 32'd0;
      m0_ack   = 1'b0;
      m1_dat_r = 32'd0;
      m1_ack   = 1'b0;
      if (gnt0) begin
         s_adr    = m0_adr;
         s_dat_w  = m0_dat_w;
         s_sel    = m0_sel;
         s_we     = m0_we;
         s_stb    = m0_stb;
         s_cyc    = m0_cyc;
         m0_dat_r = s_dat_r;
         m0_ack   = s_ack & ~reset;
      end else if (gnt1) begin
         s_adr    = m1_adr;
         s_dat_w  = m1_dat_w;
         s_sel    = m1_sel;
         s_we     = m1_we;
         s_stb    = m1_stb;
         s_cyc    = m1_cyc;
         m1_dat_r = s_dat_r;
         m1_ack   = s_ack & ~reset;
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   assign m0_err = err_q & ~own_q & ~reset;
   assign m1_err = err_q &  own_q & ~reset;
`else
   assign m0_err = 1'b0;
   assign m1_err = 1'b0;
`endif

   assign gnt = {gnt1, gnt0};

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter timeout_cycles, default 255, meaning cycles without slave ack before the pending strobe is aborted (8-bit counter range, 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports m0_adr/m0_dat_w  input  32 each, m0_sel  input  4, m0_we/m0_stb/m0_cyc  input  1 each: master 0 (LM32 instruction bus) request.
REQ-005 SHALL have ports m0_dat_r  output  32, m0_ack/m0_err  output  1 each: master 0 response.
REQ-006 SHALL have ports m1_* identical to m0_*: master 1 (LM32 data bus).
REQ-007 SHALL have ports s_adr/s_dat_w  output  32 each, s_sel  output  4, s_we/s_stb/s_cyc  output  1 each, s_dat_r  input  32, s_ack  input  1: shared slave (DDR controller).
REQ-008 SHALL have port gnt  output  2  one-hot grant, for debug.

Function
REQ-009 SHALL implement FSM states IDLE, GNT0, GNT1, ABORT.
REQ-010 IDLE: if exactly one mX_cyc is high, SHALL enter GNTX next cycle.
REQ-011 IDLE, both cyc high: SHALL grant the master not granted last (round-robin); the last-grant flag resets to 1, so master 0 wins the first tie.
REQ-012 Latency: request in IDLE at edge N SHALL produce s_cyc/s_stb driven from that master from edge N+1; no combinational path from mX_cyc to gnt.
REQ-013 GNTX: s_adr, s_dat_w, s_sel, s_we, s_stb, s_cyc SHALL follow master X combinationally; the other master's inputs SHALL be ignored.
REQ-014 GNTX: mX_ack = s_ack and mX_dat_r = s_dat_r; the non-granted master SHALL see ack=0, err=0, dat_r=0.
REQ-015 Grant SHALL be held while mX_cyc stays high (locked bursts); on mX_cyc low SHALL return to IDLE next cycle and update last-grant to X.
REQ-016 Every cycle through IDLE SHALL cost one cycle; back-to-back cycles of different masters are separated by at least one idle slave cycle.
REQ-017 In IDLE and ABORT, s_cyc and s_stb SHALL be 0; other s_* outputs SHALL be 0.
REQ-018 s_ack arriving while not in GNT0/GNT1 SHALL be ignored.
REQ-019 Timeout counter (8 bit) SHALL clear on entering GNTX and on every s_ack, and increment each cycle with s_stb high and s_ack low.
REQ-020 Counter reaching timeout_cycles in GNTX SHALL move to ABORT; mX_err pulses high for exactly the first ABORT cycle; s_cyc is dropped.
REQ-021 ABORT SHALL hold until mX_cyc goes low, then enter IDLE and update last-grant to X.
REQ-022 Same-cycle s_ack and counter terminal value: ack SHALL win; no abort.

Reset
REQ-023 Reset SHALL force state IDLE, gnt=2'b00, counter=0, last-grant=1, all mX_ack/mX_err=0, all s_* outputs 0, taking effect at the first rising edge with reset high, including mid-burst.
REQ-024 A slave ack arriving in the cycle reset is sampled SHALL not reach any master.

Configuration
REQ-025 Macro WB_ARB_TIMEOUT_EN defined: timeout counter, ABORT state and mX_err behaviour SHALL be present as above.
REQ-026 Macro WB_ARB_TIMEOUT_EN undefined: no counter or ABORT state; mX_err SHALL be tied to 0; a granted master waits indefinitely for s_ack.

Verification
REQ-027 Reset, then m1 raises cyc/stb, adr=32'h4000_0010, we=0; slave acks 3 cycles later with dat 32'hCAFEBABE -> gnt=2'b10 one cycle after request; m1_ack for one cycle with m1_dat_r=32'hCAFEBABE; m0_ack stays 0.
REQ-028 Both masters raise cyc in the same cycle after reset -> m0 granted first; after m0 drops cyc, m1 granted two cycles later (one IDLE cycle); next tie goes to m0.
REQ-029 m0 holds cyc over 4 stb/ack beats while m1 requests continuously -> gnt stays 2'b01 for all 4 beats; m1 is granted only after m0_cyc falls.
REQ-030 WB_ARB_TIMEOUT_EN defined, timeout_cycles=16, slave never acks -> m0_err high for exactly 1 cycle 16 cycles after stb; s_cyc falls the same cycle; IDLE follows m0_cyc low.
REQ-031 Reset asserted for 1 cycle mid-burst of m1 -> the next edge shows gnt=0 and s_cyc=0; after release with m1_cyc still high, m1 is re-granted one cycle later.
REQ-032 WB_ARB_TIMEOUT_EN undefined, slave silent for 1000 cycles -> no err, gnt held throughout, late s_ack completes the cycle normally.
